// File: rtl/ram_stream_reader_pkg.sv
// Shared types and helpers for the RAM read-side stream sequencer.
package ram_stream_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  // Modulo increment that also wraps correctly for non-power-of-2 moduli.
  function automatic int unsigned wrap_inc(input int unsigned value, input int unsigned modulus);
    return (value + 1 >= modulus) ? 0 : value + 1;
  endfunction

endpackage

// File: rtl/ram_stream_reader_if.sv
// Command, RAM read port and output stream of the reader, bundled as one interface.
interface ram_stream_reader_if #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 32
);
  localparam int ADDR_LEN = $clog2(DEPTH);

  logic                cmd_valid;
  logic                cmd_ready;
  logic [ADDR_LEN-1:0] cmd_base;
  logic [ADDR_LEN:0]   cmd_len;
  logic                ram_valid_addr;
  logic [ADDR_LEN-1:0] ram_r_addr;
  logic [WIDTH-1:0]    ram_r_data;
  logic                m_valid;
  logic                m_ready;
  logic [WIDTH-1:0]    m_data;
  logic                m_last;
  logic                done;

  modport master (
    input  cmd_valid, cmd_base, cmd_len, ram_r_data, m_ready,
    output cmd_ready, ram_valid_addr, ram_r_addr, m_valid, m_data, m_last, done
  );

  modport slave (
    output cmd_valid, cmd_base, cmd_len, ram_r_data, m_ready,
    input  cmd_ready, ram_valid_addr, ram_r_addr, m_valid, m_data, m_last, done
  );
endinterface

// File: rtl/ram_stream_reader_sync_fifo.sv
// Small synchronous FIFO with occupancy count; head entry is visible combinationally.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (i_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; a push into a full FIFO only happens alongside a pop of the same slot.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (i_push && !i_pop) |-> (r_count != CNT_W'(DEPTH)));
endmodule

// File: rtl/ram_stream_reader.sv
// Turns a (base, length) command into RAM reads and a back-pressured word stream with last/done.
module ram_stream_reader
  import ram_stream_reader_pkg::*;
#(
  parameter int DEPTH      = 32,
  parameter int WIDTH      = 32,
  parameter int FIFO_DEPTH = 2
) (
  input logic               clk,
  input logic               rst_n,
  ram_stream_reader_if.master bus
);
  localparam int ADDR_LEN = $clog2(DEPTH);
  localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam int CRD_W    = CNT_W + 1;

  typedef struct packed {
    logic             last;
    logic [WIDTH-1:0] data;
  } beat_t;

  rd_state_e           r_state, w_state_next;
  logic [ADDR_LEN-1:0] r_addr, w_addr_next;
  logic [ADDR_LEN:0]   r_remaining, w_remaining_next;
  logic                r_inflight;
  logic                r_last_q;
  logic                r_done_zero;
  logic                w_issue;
  logic                w_tag_last;
  logic                w_accept;
  logic                w_pop;
  logic                w_fifo_empty;
  logic [CNT_W-1:0]    w_fifo_count;
  logic [CRD_W-1:0]    w_credit;
  beat_t               w_push_beat;
  beat_t               w_head_beat;

  assign w_accept = bus.cmd_valid && bus.cmd_ready;
  assign w_pop    = !w_fifo_empty && bus.m_ready;
  // Slots already committed: buffered words plus the read in flight, less the word leaving now.
  assign w_credit = CRD_W'(w_fifo_count) + CRD_W'(r_inflight) - CRD_W'(w_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_addr      <= '0;
      r_remaining <= '0;
      r_inflight  <= 1'b0;
      r_last_q    <= 1'b0;
      r_done_zero <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_addr      <= w_addr_next;
      r_remaining <= w_remaining_next;
      r_inflight  <= w_issue;
      r_last_q    <= w_tag_last;
      r_done_zero <= w_accept && (bus.cmd_len == '0);
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_addr_next      = r_addr;
    w_remaining_next = r_remaining;
    w_issue          = 1'b0;
    w_tag_last       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept && (bus.cmd_len != '0)) begin
          w_addr_next      = bus.cmd_base;
          w_remaining_next = bus.cmd_len;
          w_state_next     = ISSUE;
        end
      end
      ISSUE: begin
        if (w_credit < CRD_W'(FIFO_DEPTH)) begin
          w_issue          = 1'b1;
          w_addr_next      = ADDR_LEN'(wrap_inc(32'(r_addr), 32'(DEPTH)));
          w_remaining_next = r_remaining - 1'b1;
          if (r_remaining == (ADDR_LEN + 1)'(1)) begin
            w_tag_last   = 1'b1;
            w_state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (w_pop && w_head_beat.last) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign w_push_beat = '{last: r_last_q, data: bus.ram_r_data};

  sync_fifo #(
    .WIDTH (WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_data  (w_push_beat),
    .i_pop   (w_pop),
    .o_data  (w_head_beat),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign bus.cmd_ready      = rst_n && (r_state == IDLE);
  assign bus.ram_valid_addr = w_issue;
  assign bus.ram_r_addr     = r_addr;
  assign bus.m_valid        = !w_fifo_empty;
  assign bus.m_data         = w_head_beat.data;
  assign bus.m_last         = !w_fifo_empty && w_head_beat.last;
  assign bus.done           = r_done_zero || (w_pop && w_head_beat.last && (r_state == DRAIN));

  a_len_legal: assert property (@(posedge clk) disable iff (!rst_n)
    w_accept |-> (bus.cmd_len <= (ADDR_LEN + 1)'(DEPTH)));
endmodule

// File: tb/tb_ram_stream_reader.sv
// Randomized bench for ram_stream_reader against a queue-based model of the expected stream.
module tb_ram_stream_reader;
  localparam int DEPTH      = 32;
  localparam int WIDTH      = 32;
  localparam int FIFO_DEPTH = 2;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_stream_reader_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bif();

  ram_stream_reader #(
    .DEPTH      (DEPTH),
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif.master)
  );

  // RAM with one-cycle read latency; garbage on the data bus when no read was strobed.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] ram_q;
  always @(posedge clk) begin
    if (bif.ram_valid_addr) ram_q <= mem[bif.ram_r_addr];
    else                    ram_q <= $urandom;
  end
  assign bif.ram_r_data = ram_q;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int    exp_addr_q[$];
  beat_t exp_beat_q[$];
  int    ready_mode = 0;
  int    cyc = 0, acc_cyc = 0, last_issue_cyc = 0, last_beat_cyc = 0;
  int    issue_cnt = 0, beat_cnt = 0;
  bit    strict = 0, zero_pend = 0, cmd_complete = 0, acc_seen = 0, mvalid_seen = 0;

  initial begin
    bif.m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       bif.m_ready = 1'b1;
        1:       bif.m_ready = 1'($urandom % 2);
        default: bif.m_ready = 1'b0;
      endcase
    end
  end

  // Monitor: compares strobes and beats with the model, builds the model on each accept.
  always @(negedge clk) begin
    bit    exp_done;
    int    a;
    beat_t b;
    if (rst_n) begin
      cyc++;
      exp_done  = zero_pend;
      zero_pend = 0;
      if (bif.ram_valid_addr) begin
        if (exp_addr_q.size() == 0) chk("addr_extra", 64'(bif.ram_r_addr), 64'hffff);
        else begin
          a = exp_addr_q.pop_front();
          chk("addr", 64'(bif.ram_r_addr), 64'(a));
        end
        if (strict) begin
          if (issue_cnt == 0) chk("lat_issue", 64'(cyc - acc_cyc), 64'd1);
          else                chk("issue_gap", 64'(cyc - last_issue_cyc), 64'd1);
        end
        last_issue_cyc = cyc;
        issue_cnt++;
      end
      if (bif.m_valid) begin
        if (exp_beat_q.size() == 0) chk("beat_extra", 64'(bif.m_valid), 64'd0);
        else begin
          b = exp_beat_q[0];
          chk("data", 64'(bif.m_data), 64'(b.data));
          chk("last", 64'(bif.m_last), 64'(b.last));
          if (strict && !mvalid_seen) chk("lat_mvalid", 64'(cyc - acc_cyc), 64'd3);
          mvalid_seen = 1;
          if (bif.m_ready) begin
            if (strict && beat_cnt > 0) chk("beat_gap", 64'(cyc - last_beat_cyc), 64'd1);
            last_beat_cyc = cyc;
            beat_cnt++;
            if (b.last) exp_done = 1;
            void'(exp_beat_q.pop_front());
          end
        end
      end
      chk("done", 64'(bif.done), 64'(exp_done));
      if (exp_done) cmd_complete = 1;
      if (bif.cmd_valid && bif.cmd_ready) begin
        acc_seen    = 1;
        acc_cyc     = cyc;
        issue_cnt   = 0;
        beat_cnt    = 0;
        mvalid_seen = 0;
        strict      = (ready_mode == 0);
        if (bif.cmd_len == 0) zero_pend = 1;
        for (int i = 0; i < int'(bif.cmd_len); i++) begin
          a = (int'(bif.cmd_base) + i) % DEPTH;
          exp_addr_q.push_back(a);
          b.data = mem[a];
          b.last = (i == int'(bif.cmd_len) - 1);
          exp_beat_q.push_back(b);
        end
      end
    end
  end

  task automatic post_reset_checks(input string pfx);
    chk({pfx, "_cmd_ready"}, 64'(bif.cmd_ready), 64'd1);
    chk({pfx, "_ram_valid_addr"}, 64'(bif.ram_valid_addr), 64'd0);
    chk({pfx, "_m_valid"}, 64'(bif.m_valid), 64'd0);
    chk({pfx, "_m_last"}, 64'(bif.m_last), 64'd0);
    chk({pfx, "_done"}, 64'(bif.done), 64'd0);
  endtask

  task automatic wait_complete(input int base, input int len);
    for (int c = 0; c < 3000 && !cmd_complete; c++) begin
      @(negedge clk);
      #2;
    end
    chk("complete", 64'(cmd_complete), 64'd1);
    chk("issues", 64'(issue_cnt), 64'(len));
    chk("beats", 64'(beat_cnt), 64'(len));
    chk("leftover", 64'(exp_beat_q.size()), 64'd0);
    $display("cmd base=%0d len=%0d mode=%0d issues=%0d beats=%0d", base, len, ready_mode,
             issue_cnt, beat_cnt);
    @(negedge clk);
  endtask

  task automatic run_cmd(input int base, input int len, input int mode, input bit wait_done);
    ready_mode   = mode;
    cmd_complete = 0;
    acc_seen     = 0;
    @(posedge clk);
    #1;
    bif.cmd_valid = 1'b1;
    bif.cmd_base  = 5'(base);
    bif.cmd_len   = 6'(len);
    for (int c = 0; c < 50 && !acc_seen; c++) begin
      @(negedge clk);
      #2;
    end
    chk("cmd_accept", 64'(acc_seen), 64'd1);
    @(posedge clk);
    #1;
    bif.cmd_valid = 1'b0;
    if (wait_done) wait_complete(base, len);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    foreach (mem[i]) mem[i] = $urandom;
    bif.cmd_valid = 1'b0;
    bif.cmd_base  = '0;
    bif.cmd_len   = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", 64'(bif.cmd_ready), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    #2;
    post_reset_checks("init");

    run_cmd(3, 4, 0, 1);
    run_cmd(30, 4, 0, 1);

    // Stalled sink: only FIFO_DEPTH reads may be issued before the stream backs up.
    run_cmd(7, 8, 2, 0);
    repeat (10) begin
      @(negedge clk);
      #2;
    end
    chk("stall_issues", 64'(issue_cnt), 64'(FIFO_DEPTH));
    chk("stall_beats", 64'(beat_cnt), 64'd0);
    ready_mode = 0;
    wait_complete(7, 8);

    run_cmd(0, 32, 1, 1);
    run_cmd(5, 0, 0, 1);

    // Reset in the middle of a command, during the third beat.
    run_cmd(0, 6, 0, 0);
    for (int c = 0; c < 50 && beat_cnt < 3; c++) begin
      @(negedge clk);
      #2;
    end
    chk("rst_at_beat3", 64'(beat_cnt), 64'd3);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_addr_q.delete();
    exp_beat_q.delete();
    zero_pend = 0;
    @(negedge clk);
    #2;
    post_reset_checks("mid");
    run_cmd(0, 2, 0, 1);

    for (int t = 0; t < 6; t++) begin
      run_cmd(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH)),
              int'($urandom_range(0, 1)), 1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
